sdfa_result_classifier: RTL and testbench
=========================================

SDFA_RESULT_CLASSIFIER -- requirements
Module: sdfa_result_classifier

Interface
REQ-001 Parameters SHALL be: NUM_CLASS, 10, number of output neurons per timestep; NUM_STEP, 8, timesteps per inference; ACC_W, 14, per-class accumulator width.
REQ-002 Port clk, input, 1, single clock for all state; rising edge active.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port result_value, input, 10, output-block value for the current class.
REQ-005 Port result_spike_valid, input, 1, result_value is valid this cycle; no backpressure to the producer.
REQ-006 Port abort, input, 1, synchronous discard of the current inference.
REQ-007 Port in_ready, output, 1, high only in ACCUM.
REQ-008 Port class_id, output, 4, winning class index.
REQ-009 Port class_score, output, ACC_W, accumulated score of the winner.
REQ-010 Port class_sat, output, 1, some accumulator saturated during this inference.
REQ-011 Port class_valid, output, 1, result available.
REQ-012 Port class_ready, input, 1, consumer accepts the result.
REQ-013 Port drop_err, output, 1, one-cycle pulse when a valid value is discarded.

Function
REQ-014 The FSM SHALL have states ACCUM, ARGMAX and DONE.
REQ-015 In ACCUM, each result_spike_valid beat SHALL add zero-extended result_value to acc[cls_idx].
- cls_idx advances 0..NUM_CLASS-1 and wraps to 0.
- On wrap, step_idx increments.
REQ-016 Accumulation SHALL saturate at 2^ACC_W-1 and set the sticky sat flag; values never wrap.
REQ-017 The beat with cls_idx=NUM_CLASS-1 and step_idx=NUM_STEP-1 (call its cycle T) SHALL move the FSM to ARGMAX at T+1.
REQ-018 ARGMAX SHALL scan one class per cycle over NUM_CLASS cycles.
- A strictly greater score replaces the current best.
- Ties resolve to the lower index.
REQ-019 The FSM SHALL enter DONE so that class_valid rises at cycle T+NUM_CLASS+1.
- class_id, class_score and class_sat are stable while class_valid is high.
REQ-020 In DONE, class_valid SHALL stay high until a cycle with class_ready=1.
- The next cycle: class_valid=0, all accumulators, counters and sat are zero, state is ACCUM.
REQ-021 result_spike_valid outside ACCUM SHALL be dropped: no state change, drop_err=1 for that cycle.
REQ-022 abort in any state SHALL, on the next edge, zero accumulators, counters and sat, clear class_valid and enter ACCUM.
- abort takes priority over a simultaneous valid beat or class_ready.
- A beat coinciding with abort is discarded without drop_err.
REQ-023 class_ready while class_valid=0 SHALL be ignored.
REQ-024 Back-to-back inferences SHALL be accepted.
- The first beat of the next inference is legal in the cycle immediately after the handshake.

Reset
REQ-025 While rst=1, the block SHALL hold:
- state=ACCUM, in_ready=1
- accumulators, cls_idx, step_idx, best registers all 0
- class_id=0, class_score=0, class_sat=0, class_valid=0, drop_err=0
REQ-026 rst asserted mid-inference SHALL discard all partial sums with no output.
- The first edge after release accepts a beat as class 0, step 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the defaults for NUM_CLASS, NUM_STEP and ACC_W.
- The top-level sdfa_top_sim uses the same constants to size result_value wiring.
REQ-028 One sub-module, sdfa_sat_acc, SHALL implement the saturating ACC_W adder; it SHALL be instantiated once and shared via cls_idx muxing.
REQ-029 The block SHALL connect to result_value/result_spike_valid of the output block in sdfa_top_sim, unmodified.

Verification
REQ-030 The bench SHALL cover these directed scenarios (NUM_CLASS=10 for all):
- Basic: 8 steps, class 3 receives 100 and all others 5 every step -> class_valid at T+11, class_id=3, class_score=800, class_sat=0.
- Tie: classes 2 and 7 both total 400, all others 0 -> class_id=2, class_score=400.
- Saturation, ACC_W=12: class 0 receives 1023 for all 8 steps -> class_score=4095, class_sat=1, class_id=0.
- Backpressure: class_ready held low 20 cycles, then a valid beat arrives -> class_valid stays high with stable outputs, drop_err pulses once, the next inference is unaffected.
- Abort: abort at step 4, class 5 -> next 80 beats form a clean inference matching the basic-case expectation; no class_valid before T+11.
- Reset mid-ARGMAX: rst pulsed during the scan -> all outputs 0, in_ready=1, the following inference correct.

Source files
------------

// File: rtl/sdfa_result_classifier_pkg.sv
// Shared constants and FSM state type for the SDFA result classifier.
package sdfa_result_classifier_pkg;

    localparam int NUM_CLASS_DEF = 10;
    localparam int NUM_STEP_DEF  = 8;
    localparam int ACC_W_DEF     = 14;
    localparam int VALUE_W       = 10;
    localparam int ID_W          = 4;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ARGMAX = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sdfa_result_classifier_sat_acc.sv
// Saturating adder shared by all class accumulators: acc + zero-extended value,
// clamped to all-ones when the true sum does not fit in ACC_W bits.
module sdfa_sat_acc #(
    parameter int ACC_W = 14,
    parameter int IN_W  = 10
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] full;

    assign full = {1'b0, a} + (ACC_W + 1)'(b);
    assign sat  = full[ACC_W];
    assign sum  = sat ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/sdfa_result_classifier.sv
// Accumulates per-class output values over NUM_STEP timesteps, then scans for
// the winning class (ties go to the lower index) and holds the result until
// the consumer accepts it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_ACCUM  | accepting beats, class index cycles 0..NUM_CLASS-1 per step
// ST_ARGMAX | one class compared per cycle against the running best
// ST_DONE   | result held on class_* until class_ready
module sdfa_result_classifier
    import sdfa_result_classifier_pkg::*;
#(
    parameter int NUM_CLASS = NUM_CLASS_DEF,
    parameter int NUM_STEP  = NUM_STEP_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] result_value,
    input  logic               result_spike_valid,
    input  logic               abort,
    output logic               in_ready,
    output logic [ID_W-1:0]    class_id,
    output logic [ACC_W-1:0]   class_score,
    output logic               class_sat,
    output logic               class_valid,
    input  logic               class_ready,
    output logic               drop_err
);

    localparam int STEP_W = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1;

    state_t            state;
    logic [ACC_W-1:0]  acc [NUM_CLASS];
    logic [ID_W-1:0]   cls_idx;
    logic [STEP_W-1:0] step_idx;
    logic [ID_W-1:0]   best_id;
    logic [ACC_W-1:0]  best_score;
    logic              sat_flag;

    logic [ACC_W-1:0]  cur_acc;
    logic [ACC_W-1:0]  sum;
    logic              sum_sat;
    logic              last_cls;
    logic              last_step;
    logic              better;
    logic              clear;

    // cls_idx selects the accumulator both for adding and for the argmax scan
    assign cur_acc   = acc[cls_idx];
    assign last_cls  = (cls_idx == ID_W'(NUM_CLASS - 1));
    assign last_step = (step_idx == STEP_W'(NUM_STEP - 1));
    assign better    = (cur_acc > best_score);
    assign clear     = abort || ((state == ST_DONE) && class_ready);
    assign drop_err  = result_spike_valid && !abort && (state != ST_ACCUM);

    sdfa_sat_acc #(
        .ACC_W (ACC_W),
        .IN_W  (VALUE_W)
    ) u_sat_acc (
        .a   (cur_acc),
        .b   (result_value),
        .sum (sum),
        .sat (sum_sat)
    );

    // Main FSM: accumulation, argmax scan and result hold, with abort/handshake clearing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ACCUM;
            in_ready    <= 1'b1;
            for (int i = 0; i < NUM_CLASS; i++) acc[i] <= '0;
            cls_idx     <= '0;
            step_idx    <= '0;
            best_id     <= '0;
            best_score  <= '0;
            sat_flag    <= 1'b0;
            class_id    <= '0;
            class_score <= '0;
            class_sat   <= 1'b0;
            class_valid <= 1'b0;
        end else if (clear) begin
            state       <= ST_ACCUM;
            in_ready    <= 1'b1;
            for (int i = 0; i < NUM_CLASS; i++) acc[i] <= '0;
            cls_idx     <= '0;
            step_idx    <= '0;
            best_id     <= '0;
            best_score  <= '0;
            sat_flag    <= 1'b0;
            class_id    <= '0;
            class_score <= '0;
            class_sat   <= 1'b0;
            class_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (result_spike_valid) begin
                        acc[cls_idx] <= sum;
                        if (sum_sat) sat_flag <= 1'b1;
                        if (last_cls) begin
                            cls_idx <= '0;
                            if (last_step) begin
                                step_idx <= '0;
                                state    <= ST_ARGMAX;
                                in_ready <= 1'b0;
                            end else begin
                                step_idx <= step_idx + STEP_W'(1);
                            end
                        end else begin
                            cls_idx <= cls_idx + ID_W'(1);
                        end
                    end
                end
                ST_ARGMAX: begin
                    if (better) begin
                        best_score <= cur_acc;
                        best_id    <= cls_idx;
                    end
                    if (last_cls) begin
                        // fold the final comparison straight into the outputs
                        cls_idx     <= '0;
                        state       <= ST_DONE;
                        class_valid <= 1'b1;
                        class_id    <= better ? cls_idx : best_id;
                        class_score <= better ? cur_acc : best_score;
                        class_sat   <= sat_flag;
                    end else begin
                        cls_idx <= cls_idx + ID_W'(1);
                    end
                end
                ST_DONE: begin
                    // hold until class_ready, handled by clear above
                end
                default: begin
                    state    <= ST_ACCUM;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdfa_result_classifier.sv
// Self-checking bench: two classifiers (ACC_W=14 and ACC_W=12) share stimulus
// and are compared against a per-class sum/clamp/argmax reference model.
module tb_sdfa_result_classifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  result_value = '0;
    logic        result_spike_valid = 1'b0;
    logic        abort = 1'b0;
    logic        class_ready = 1'b0;

    logic        in_ready_a, class_sat_a, class_valid_a, drop_err_a;
    logic [3:0]  class_id_a;
    logic [13:0] class_score_a;
    logic        in_ready_b, class_sat_b, class_valid_b, drop_err_b;
    logic [3:0]  class_id_b;
    logic [11:0] class_score_b;

    int checks = 0;
    int failures = 0;
    int unsigned vals [10][8];

    typedef struct { int unsigned id; int unsigned score; bit sat; } res_t;
    typedef struct {
        int lat;
        logic [3:0] id_a; logic [13:0] sc_a; logic sat_a;
        logic [3:0] id_b; logic [11:0] sc_b; logic sat_b;
    } obs_t;

    always #5 clk = ~clk;

    sdfa_result_classifier #(.NUM_CLASS(10), .NUM_STEP(8), .ACC_W(14)) dut_a (
        .clk(clk), .rst(rst), .result_value(result_value),
        .result_spike_valid(result_spike_valid), .abort(abort),
        .in_ready(in_ready_a), .class_id(class_id_a), .class_score(class_score_a),
        .class_sat(class_sat_a), .class_valid(class_valid_a),
        .class_ready(class_ready), .drop_err(drop_err_a));

    sdfa_result_classifier #(.NUM_CLASS(10), .NUM_STEP(8), .ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .result_value(result_value),
        .result_spike_valid(result_spike_valid), .abort(abort),
        .in_ready(in_ready_b), .class_id(class_id_b), .class_score(class_score_b),
        .class_sat(class_sat_b), .class_valid(class_valid_b),
        .class_ready(class_ready), .drop_err(drop_err_b));

    // Reference: total per class, clamp at 2^accw-1, first index with the max wins
    function automatic res_t model(input int accw);
        res_t r;
        int unsigned mx, tot, best;
        mx = (32'd1 << accw) - 1;
        best = 0; r.id = 0; r.sat = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tot = 0;
            for (int s = 0; s < 8; s++) tot += vals[c][s];
            if (tot > mx) begin r.sat = 1'b1; tot = mx; end
            if (c == 0 || tot > best) begin best = tot; r.id = c; end
        end
        r.score = best;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_vals(input int unsigned hi);
        for (int c = 0; c < 10; c++)
            for (int s = 0; s < 8; s++) vals[c][s] = $urandom_range(hi, 0);
    endtask

    task automatic fill_basic();
        for (int c = 0; c < 10; c++)
            for (int s = 0; s < 8; s++) vals[c][s] = (c == 3) ? 100 : 5;
    endtask

    // Stream all 80 beats (class-major within each step); returns beats driven while in_ready was low
    task automatic feed(input bit gaps, output int busy);
        busy = 0;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 10; c++) begin
                if (gaps) begin
                    result_spike_valid = 1'b0;
                    repeat ($urandom_range(2, 0)) cyc();
                end
                result_spike_valid = 1'b1;
                result_value = 10'(vals[c][s]);
                if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) busy++;
                cyc();
            end
        end
        result_spike_valid = 1'b0;
        result_value = '0;
    endtask

    // Wait (bounded) for class_valid after the last beat; lat counts cycles from T
    task automatic wait_result(output obs_t o);
        int n;
        n = 1;
        while (!(class_valid_a === 1'b1 && class_valid_b === 1'b1) && n < 40) begin
            cyc();
            n++;
        end
        o.lat = n;
        o.id_a = class_id_a; o.sc_a = class_score_a; o.sat_a = class_sat_a;
        o.id_b = class_id_b; o.sc_b = class_score_b; o.sat_b = class_sat_b;
    endtask

    task automatic handshake();
        class_ready = 1'b1;
        cyc();
        class_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        result_spike_valid = 1'b1;
        class_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (in_ready_a !== 1'b1 || class_valid_a !== 1'b0 || class_id_a !== 4'd0 ||
            class_score_a !== 14'd0 || class_sat_a !== 1'b0 || drop_err_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_acc14 got rdy=%0b v=%0b id=%0d sc=%0d sat=%0b drop=%0b want 1 0 0 0 0 0",
                     in_ready_a, class_valid_a, class_id_a, class_score_a, class_sat_a, drop_err_a);
        end
        checks++;
        if (in_ready_b !== 1'b1 || class_valid_b !== 1'b0 || class_id_b !== 4'd0 ||
            class_score_b !== 12'd0 || class_sat_b !== 1'b0 || drop_err_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_acc12 got rdy=%0b v=%0b id=%0d sc=%0d sat=%0b drop=%0b want 1 0 0 0 0 0",
                     in_ready_b, class_valid_b, class_id_b, class_score_b, class_sat_b, drop_err_b);
        end
        result_spike_valid = 1'b0;
        class_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        obs_t o; res_t ea, eb; int busy;
        fill_basic();
        ea = model(14); eb = model(12);
        feed(1'b0, busy);
        wait_result(o);
        checks++;
        if (busy != 0 || o.lat != 11) begin
            failures++; $display("FAIL basic_timing got busy=%0d lat=%0d want busy=0 lat=11", busy, o.lat);
        end
        checks++;
        if (o.id_a !== 4'd3 || o.sc_a !== 14'd800 || o.sat_a !== 1'b0 || ea.score != 800) begin
            failures++; $display("FAIL basic_acc14 got id=%0d sc=%0d sat=%0b want id=3 sc=800 sat=0", o.id_a, o.sc_a, o.sat_a);
        end
        checks++;
        if (o.id_b !== 4'(eb.id) || o.sc_b !== 12'(eb.score) || o.sat_b !== eb.sat) begin
            failures++; $display("FAIL basic_acc12 got id=%0d sc=%0d sat=%0b want id=%0d sc=%0d sat=%0b",
                                 o.id_b, o.sc_b, o.sat_b, eb.id, eb.score, eb.sat);
        end
        handshake();
        checks++;
        if (class_valid_a !== 1'b0 || class_valid_b !== 1'b0 || in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            failures++; $display("FAIL basic_release got valid=%0b/%0b rdy=%0b/%0b want valid=0 rdy=1",
                                 class_valid_a, class_valid_b, in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_tie();
        obs_t o; int busy;
        for (int c = 0; c < 10; c++)
            for (int s = 0; s < 8; s++) vals[c][s] = (c == 2 || c == 7) ? 50 : 0;
        feed(1'b1, busy);
        wait_result(o);
        checks++;
        if (busy != 0 || o.lat != 11) begin
            failures++; $display("FAIL tie_timing got busy=%0d lat=%0d want busy=0 lat=11", busy, o.lat);
        end
        checks++;
        if (o.id_a !== 4'd2 || o.sc_a !== 14'd400 || o.id_b !== 4'd2 || o.sc_b !== 12'd400) begin
            failures++; $display("FAIL tie_result got id=%0d/%0d sc=%0d/%0d want id=2 sc=400",
                                 o.id_a, o.id_b, o.sc_a, o.sc_b);
        end
        handshake();
    endtask

    task automatic test_saturation();
        obs_t o; int busy;
        for (int c = 0; c < 10; c++)
            for (int s = 0; s < 8; s++) vals[c][s] = (c == 0) ? 1023 : 0;
        feed(1'b0, busy);
        wait_result(o);
        checks++;
        if (o.lat != 11 || o.id_b !== 4'd0 || o.sc_b !== 12'd4095 || o.sat_b !== 1'b1) begin
            failures++; $display("FAIL sat_acc12 got lat=%0d id=%0d sc=%0d sat=%0b want lat=11 id=0 sc=4095 sat=1",
                                 o.lat, o.id_b, o.sc_b, o.sat_b);
        end
        checks++;
        if (o.id_a !== 4'd0 || o.sc_a !== 14'd8184 || o.sat_a !== 1'b0) begin
            failures++; $display("FAIL sat_acc14 got id=%0d sc=%0d sat=%0b want id=0 sc=8184 sat=0",
                                 o.id_a, o.sc_a, o.sat_a);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        obs_t o; res_t ea, eb; int busy, pa, pb, bad;
        fill_vals(1023);
        ea = model(14); eb = model(12);
        feed(1'b0, busy);
        wait_result(o);
        checks++;
        if (o.lat != 11) begin
            failures++; $display("FAIL bp_latency got=%0d want=11", o.lat);
        end
        pa = 0; pb = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            result_spike_valid = (i == 19);
            result_value = 10'd777;
            #1;
            if (drop_err_a === 1'b1) pa++;
            if (drop_err_b === 1'b1) pb++;
            if (class_valid_a !== 1'b1 || class_id_a !== 4'(ea.id) || class_score_a !== 14'(ea.score) ||
                class_sat_a !== ea.sat || class_valid_b !== 1'b1 || class_id_b !== 4'(eb.id) ||
                class_score_b !== 12'(eb.score) || class_sat_b !== eb.sat) bad++;
            cyc();
        end
        result_spike_valid = 1'b0;
        result_value = '0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_hold got %0d unstable cycles want 0 (want id=%0d sc=%0d/%0d)",
                                 bad, ea.id, ea.score, eb.score);
        end
        checks++;
        if (pa != 1 || pb != 1) begin
            failures++; $display("FAIL bp_drop_pulses got %0d/%0d want 1", pa, pb);
        end
        handshake();
        // next inference starts the very cycle after the handshake
        fill_vals(1023);
        ea = model(14); eb = model(12);
        feed(1'b0, busy);
        wait_result(o);
        checks++;
        if (busy != 0 || o.lat != 11 || o.id_a !== 4'(ea.id) || o.sc_a !== 14'(ea.score) ||
            o.id_b !== 4'(eb.id) || o.sc_b !== 12'(eb.score) || o.sat_b !== eb.sat) begin
            failures++; $display("FAIL bp_next got busy=%0d lat=%0d id=%0d sc=%0d/%0d want lat=11 id=%0d sc=%0d/%0d",
                                 busy, o.lat, o.id_a, o.sc_a, o.sc_b, ea.id, ea.score, eb.score);
        end
        handshake();
    endtask

    task automatic test_abort();
        obs_t o; int busy;
        for (int k = 0; k <= 45; k++) begin
            result_spike_valid = 1'b1;
            result_value = 10'($urandom_range(1023, 0));
            abort = (k == 45);
            if (k == 45) begin
                #1;
                checks++;
                if (drop_err_a !== 1'b0 || drop_err_b !== 1'b0) begin
                    failures++; $display("FAIL abort_drop got %0b/%0b want 0", drop_err_a, drop_err_b);
                end
            end
            cyc();
        end
        abort = 1'b0;
        result_spike_valid = 1'b0;
        fill_basic();
        feed(1'b0, busy);
        wait_result(o);
        checks++;
        if (busy != 0 || o.lat != 11 || o.id_a !== 4'd3 || o.sc_a !== 14'd800 || o.sat_a !== 1'b0 ||
            o.id_b !== 4'd3 || o.sc_b !== 12'd800) begin
            failures++; $display("FAIL abort_clean got busy=%0d lat=%0d id=%0d sc=%0d/%0d want lat=11 id=3 sc=800",
                                 busy, o.lat, o.id_a, o.sc_a, o.sc_b);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (class_valid_a !== 1'b0 || class_valid_b !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++; $display("FAIL abort_done got valid=%0b/%0b rdy=%0b want valid=0 rdy=1",
                                 class_valid_a, class_valid_b, in_ready_a);
        end
    endtask

    task automatic test_reset_argmax();
        obs_t o; res_t ea, eb; int busy;
        fill_basic();
        feed(1'b0, busy);
        repeat (4) cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (class_valid_a !== 1'b0 || class_id_a !== 4'd0 || class_score_a !== 14'd0 || class_sat_a !== 1'b0 ||
            in_ready_a !== 1'b1 || class_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
            failures++; $display("FAIL rst_argmax got v=%0b id=%0d sc=%0d sat=%0b rdy=%0b want 0 0 0 0 1",
                                 class_valid_a, class_id_a, class_score_a, class_sat_a, in_ready_a);
        end
        cyc();
        rst = 1'b0;
        class_ready = 1'b1;
        cyc();
        class_ready = 1'b0;
        fill_vals(1023);
        ea = model(14); eb = model(12);
        feed(1'b1, busy);
        wait_result(o);
        checks++;
        if (busy != 0 || o.lat != 11 || o.id_a !== 4'(ea.id) || o.sc_a !== 14'(ea.score) || o.sat_a !== ea.sat ||
            o.id_b !== 4'(eb.id) || o.sc_b !== 12'(eb.score) || o.sat_b !== eb.sat) begin
            failures++; $display("FAIL rst_next got lat=%0d id=%0d/%0d sc=%0d/%0d want lat=11 id=%0d/%0d sc=%0d/%0d",
                                 o.lat, o.id_a, o.id_b, o.sc_a, o.sc_b, ea.id, eb.id, ea.score, eb.score);
        end
        handshake();
    endtask

    task automatic test_random();
        obs_t o; res_t ea, eb; int busy;
        for (int n = 0; n < 6; n++) begin
            fill_vals((n % 2 == 1) ? 3 : 1023);
            ea = model(14); eb = model(12);
            feed(n[0], busy);
            wait_result(o);
            repeat ($urandom_range(3, 0)) cyc();
            checks++;
            if (busy != 0 || o.lat != 11 || class_valid_a !== 1'b1 ||
                o.id_a !== 4'(ea.id) || o.sc_a !== 14'(ea.score) || o.sat_a !== ea.sat) begin
                failures++; $display("FAIL rand%0d_acc14 got lat=%0d v=%0b id=%0d sc=%0d sat=%0b want lat=11 v=1 id=%0d sc=%0d sat=%0b",
                                     n, o.lat, class_valid_a, o.id_a, o.sc_a, o.sat_a, ea.id, ea.score, ea.sat);
            end
            checks++;
            if (o.id_b !== 4'(eb.id) || o.sc_b !== 12'(eb.score) || o.sat_b !== eb.sat) begin
                failures++; $display("FAIL rand%0d_acc12 got id=%0d sc=%0d sat=%0b want id=%0d sc=%0d sat=%0b",
                                     n, o.id_b, o.sc_b, o.sat_b, eb.id, eb.score, eb.sat);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_argmax();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
